// File: rtl/range_tracker8.sv
// range_tracker8: streaming window max/min/spread tracker.
// Samples arrive on a valid/ready input stream. After COUNT accepted samples,
// the window maximum, minimum and spread are registered and presented on a
// valid/ready output stream.
// Optional build macro: RANGE_TRACKER_SIGNED_EN selects two's-complement
// compares. out_diff is always an unsigned WIDTH-bit magnitude.
module range_tracker8 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned COUNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_REPORT  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic [WIDTH-1:0] run_min_q, run_min_d;
    logic [WIDTH-1:0] out_max_d, out_min_d, out_diff_d;
    logic             out_valid_d;

    logic             accept;
    logic [WIDTH-1:0] win_max, win_min;

    // Ordering used by every compare: signed or unsigned depending on build.
    function automatic logic greater(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
`ifdef RANGE_TRACKER_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Ready only while collecting; held low throughout reset.
    assign in_ready = rst_n & (state_q == ST_COLLECT);
    assign accept   = in_valid & in_ready;

    // Window extremes after merging the current sample; the first sample seeds both.
    always_comb begin
        win_max = run_max_q;
        win_min = run_min_q;
        if (cnt_q == '0) begin
            win_max = in_data;
            win_min = in_data;
        end else begin
            if (greater(in_data, run_max_q)) begin
                win_max = in_data;
            end
            if (greater(run_min_q, in_data)) begin
                win_min = in_data;
            end
        end
    end

    // Next-state and next-register logic; clear overrides accept and out_ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        run_min_d   = run_min_q;
        out_max_d   = out_max;
        out_min_d   = out_min;
        out_diff_d  = out_diff;
        out_valid_d = out_valid;

        if (clear) begin
            state_d     = ST_COLLECT;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        run_max_d = win_max;
                        run_min_d = win_min;
                        if (cnt_q == CNT_LAST) begin
                            out_max_d   = win_max;
                            out_min_d   = win_min;
                            out_diff_d  = win_max - win_min;
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = ST_REPORT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_REPORT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_COLLECT;
                    end
                end
                default: begin
                    state_d     = ST_COLLECT;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, window and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            run_max_q <= '0;
            run_min_q <= '0;
            out_max   <= '0;
            out_min   <= '0;
            out_diff  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            out_max   <= out_max_d;
            out_min   <= out_min_d;
            out_diff  <= out_diff_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
